// File: rtl/ipref_miss_ctrl_if.sv
// I$ miss / stream-buffer / refill bundle; names are seen from the controller side.
// The master modport is the controller. The slave modport is the I$, stream buffer and refill side.
interface ipref_miss_ctrl_if #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned LINE_WIDTH = 128
);
  logic                  miss_req_i;
  logic [PLEN-1:0]       miss_addr_i;
  logic                  miss_gnt_o;
  logic                  miss_rtrn_vld_o;
  logic [LINE_WIDTH-1:0] miss_rtrn_data_o;
  logic                  miss_rtrn_src_o;
  logic                  sb_req_o;
  logic [PLEN-1:0]       sb_addr_o;
  logic                  sb_found_i;
  logic                  sb_ready_i;
  logic [LINE_WIDTH-1:0] sb_data_i;
  logic                  mem_req_o;
  logic [PLEN-1:0]       mem_addr_o;
  logic                  mem_ack_i;
  logic                  mem_rtrn_vld_i;
  logic [LINE_WIDTH-1:0] mem_rtrn_data_i;
  logic                  hit_o;
  logic                  miss_o;
  logic                  timeout_o;

  modport master (
    input  miss_req_i, miss_addr_i, sb_found_i, sb_ready_i, sb_data_i,
           mem_ack_i, mem_rtrn_vld_i, mem_rtrn_data_i,
    output miss_gnt_o, miss_rtrn_vld_o, miss_rtrn_data_o, miss_rtrn_src_o,
           sb_req_o, sb_addr_o, mem_req_o, mem_addr_o, hit_o, miss_o, timeout_o
  );

  modport slave (
    output miss_req_i, miss_addr_i, sb_found_i, sb_ready_i, sb_data_i,
           mem_ack_i, mem_rtrn_vld_i, mem_rtrn_data_i,
    input  miss_gnt_o, miss_rtrn_vld_o, miss_rtrn_data_o, miss_rtrn_src_o,
           sb_req_o, sb_addr_o, mem_req_o, mem_addr_o, hit_o, miss_o, timeout_o
  );
endinterface

// File: rtl/ipref_miss_ctrl.sv
// Probes the stream buffer for one I$ line miss and falls back to the refill port. An SB hit returns 2 cycles after grant.
// Backpressure: only one miss is outstanding, and a new miss is granted only in IDLE. The refill request is held until it is acked.
module ipref_miss_ctrl #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WAIT_MAX   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               en_i,
  ipref_miss_ctrl_if.master  bus
);
  localparam int unsigned TW = $clog2(WAIT_MAX + 1);
  localparam logic [PLEN-1:0] OFFS_MASK = PLEN'(LINE_WIDTH / 8 - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_READY, MEM_REQ, MEM_WAIT, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [PLEN-1:0]       addr_q, addr_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  rtrn_vld_q, rtrn_vld_d;
  logic [LINE_WIDTH-1:0] rtrn_data_q, rtrn_data_d;
  logic                  rtrn_src_q, rtrn_src_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;
  logic                  timeout_q, timeout_d;
  logic                  gnt, sb_req, mem_req;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q;
    rtrn_vld_d   = 1'b0;
    rtrn_data_d  = rtrn_data_q;
    rtrn_src_d   = rtrn_src_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    timeout_d    = 1'b0;
    gnt          = 1'b0;
    sb_req       = 1'b0;
    mem_req      = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt = bus.miss_req_i & ~flush_i;
        if (gnt) begin
          addr_d  = bus.miss_addr_i & ~OFFS_MASK;
          state_d = en_i ? LOOKUP : MEM_REQ;
        end
      end
      LOOKUP: begin
        sb_req = ~flush_i;
        if (flush_i) begin
          state_d = IDLE;
        end else if (bus.sb_found_i && bus.sb_ready_i) begin
          rtrn_vld_d  = 1'b1;
          rtrn_data_d = bus.sb_data_i;
          rtrn_src_d  = 1'b0;
          hit_d       = 1'b1;
          state_d     = IDLE;
        end else if (bus.sb_found_i) begin
          timer_d = TW'(WAIT_MAX - 1);
          state_d = WAIT_READY;
        end else begin
          miss_d  = 1'b1;
          state_d = MEM_REQ;
        end
      end
      WAIT_READY: begin
        sb_req = ~flush_i;
        if (flush_i) begin
          state_d = IDLE;
        end else if (bus.sb_ready_i) begin
          rtrn_vld_d  = 1'b1;
          rtrn_data_d = bus.sb_data_i;
          rtrn_src_d  = 1'b0;
          hit_d       = 1'b1;
          state_d     = IDLE;
        end else if (!bus.sb_found_i) begin
          miss_d  = 1'b1;
          state_d = MEM_REQ;
        end else if (timer_q == '0) begin
          miss_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = MEM_REQ;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      MEM_REQ: begin
        // The request cannot be withdrawn, so a flush is remembered until the ack.
        mem_req      = 1'b1;
        flush_pend_d = flush_pend_q | flush_i;
        if (bus.mem_ack_i) begin
          state_d      = (flush_pend_q | flush_i) ? DRAIN : MEM_WAIT;
          flush_pend_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (flush_i) begin
          state_d = bus.mem_rtrn_vld_i ? IDLE : DRAIN;
        end else if (bus.mem_rtrn_vld_i) begin
          rtrn_vld_d  = 1'b1;
          rtrn_data_d = bus.mem_rtrn_data_i;
          rtrn_src_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        if (bus.mem_rtrn_vld_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      rtrn_vld_q   <= 1'b0;
      rtrn_data_q  <= '0;
      rtrn_src_q   <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      rtrn_vld_q   <= rtrn_vld_d;
      rtrn_data_q  <= rtrn_data_d;
      rtrn_src_q   <= rtrn_src_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.miss_gnt_o       = gnt;
  assign bus.miss_rtrn_vld_o  = rtrn_vld_q;
  assign bus.miss_rtrn_data_o = rtrn_data_q;
  assign bus.miss_rtrn_src_o  = rtrn_src_q;
  assign bus.sb_req_o         = sb_req;
  assign bus.sb_addr_o        = addr_q;
  assign bus.mem_req_o        = mem_req;
  assign bus.mem_addr_o       = addr_q;
  assign bus.hit_o            = hit_q;
  assign bus.miss_o           = miss_q;
  assign bus.timeout_o        = timeout_q;
endmodule
